// File: rtl/tdm_mux8to1.sv
// tdm_mux8to1: eight-lane TDM transmitter.
// Captures a frame of eight samples and serializes one slot per clock.
module tdm_mux8to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] y,
  output logic             s2,
  output logic             s1,
  output logic             s0,
  output logic             y_valid,
  output logic             frame_start,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [2:0]              slot;
  logic [2:0]              slot_nxt;
  logic [7:0][WIDTH-1:0]   hold;
  logic [7:0][WIDTH-1:0]   hold_nxt;
  logic                    accept;
  logic                    step;
  logic                    last;

  logic [WIDTH-1:0]        y_nxt;
  logic [2:0]              sel_nxt;
  logic                    v_nxt;
  logic                    fs_nxt;
  logic [WIDTH-1:0]        y_q;
  logic [2:0]              sel_q;
  logic                    v_q;
  logic                    fs_q;

  assign last       = (state == SEND) & (slot == 3'd7);
  assign load_ready = ~abort & ((state == IDLE) | last);
  assign accept     = load_valid & load_ready;
  assign step       = ~abort & ~accept & (state == SEND);

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    hold_nxt  = hold;
    unique case (1'b1)
      abort: begin
        state_nxt = IDLE;
        slot_nxt  = '0;
      end
      accept: begin
        state_nxt = SEND;
        slot_nxt  = '0;
        hold_nxt  = {d7, d6, d5, d4, d3, d2, d1, d0};
      end
      step: begin
        if (slot == 3'd7) begin
          state_nxt = IDLE;
          slot_nxt  = '0;
        end else begin
          slot_nxt  = slot + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs are registered from next-state so slot k shows right after its edge.
  always_comb begin
    v_nxt   = (state_nxt == SEND);
    y_nxt   = '0;
    sel_nxt = '0;
    fs_nxt  = 1'b0;
    if (v_nxt) begin
      y_nxt   = hold_nxt[slot_nxt];
      sel_nxt = slot_nxt;
      fs_nxt  = (slot_nxt == 3'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      slot  <= '0;
      hold  <= '0;
      y_q   <= '0;
      sel_q <= '0;
      v_q   <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      hold  <= hold_nxt;
      y_q   <= y_nxt;
      sel_q <= sel_nxt;
      v_q   <= v_nxt;
      fs_q  <= fs_nxt;
    end
  end

  assign y           = y_q;
  assign s2          = sel_q[2];
  assign s1          = sel_q[1];
  assign s0          = sel_q[0];
  assign y_valid     = v_q;
  assign busy        = v_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_tdm_mux8to1.sv
// tb_tdm_mux8to1: scoreboard plus cycle table for tdm_mux8to1.
// A WIDTH=8 and a WIDTH=1 instance share stimulus.
module tb_tdm_mux8to1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] din [8];
  logic       mon_on = 1'b1;

  logic [7:0] u8_y;
  logic       u8_s2, u8_s1, u8_s0;
  logic       u8_yv, u8_fs, u8_busy, u8_rdy;
  logic       u1_y;
  logic       u1_s2, u1_s1, u1_s0;
  logic       u1_yv, u1_fs, u1_busy, u1_rdy;
  logic [7:0] dmx;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] y;
    logic [2:0] s;
    logic       fs;
  } exp_t;

  typedef struct {
    logic       lv;
    logic       ab;
    logic       v;
    logic [7:0] y;
    logic [2:0] s;
    logic       fs;
    logic       rdy;
  } vec_t;

  exp_t sb[$];
  time  fs_t[$];
  bit   m_busy = 1'b0;
  logic [2:0] m_slot = 3'd0;
  int   acc_cnt = 0;

  always #5 clk = ~clk;

  tdm_mux8to1 #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .d0(din[0]), .d1(din[1]), .d2(din[2]), .d3(din[3]),
    .d4(din[4]), .d5(din[5]), .d6(din[6]), .d7(din[7]),
    .load_valid(load_valid), .load_ready(u8_rdy), .abort(abort),
    .y(u8_y), .s2(u8_s2), .s1(u8_s1), .s0(u8_s0),
    .y_valid(u8_yv), .frame_start(u8_fs), .busy(u8_busy)
  );

  tdm_mux8to1 #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .d0(din[0][0]), .d1(din[1][0]), .d2(din[2][0]), .d3(din[3][0]),
    .d4(din[4][0]), .d5(din[5][0]), .d6(din[6][0]), .d7(din[7][0]),
    .load_valid(load_valid), .load_ready(u1_rdy), .abort(abort),
    .y(u1_y), .s2(u1_s2), .s1(u1_s1), .s0(u1_s0),
    .y_valid(u1_yv), .frame_start(u1_fs), .busy(u1_busy)
  );

  // Loopback demux1to8 gated by y_valid.
  always_comb begin
    dmx = 8'h00;
    if (u1_yv) dmx = 8'(u1_y) << {u1_s2, u1_s1, u1_s0};
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got none expected event", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pushes the eight expected slots on each accepted load.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || abort) begin
        m_busy = 1'b0;
        m_slot = 3'd0;
        sb.delete();
      end else if (load_valid && (!m_busy || m_slot == 3'd7)) begin
        for (int k = 0; k < 8; k++)
          sb.push_back('{y: din[k], s: 3'(k), fs: (k == 0)});
        m_busy = 1'b1;
        m_slot = 3'd0;
        acc_cnt++;
      end else if (m_busy) begin
        if (m_slot == 3'd7) m_busy = 1'b0;
        else m_slot = m_slot + 3'd1;
      end
    end
  end

  initial begin
    exp_t e;
    logic rdy;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        rdy = ~abort & (~m_busy | (m_slot == 3'd7));
        chk("ready8", u8_rdy, rdy);
        chk("ready1", u1_rdy, rdy);
        if (u8_fs) fs_t.push_back($time);
        if (m_busy) begin
          if (sb.size() == 0) begin
            fail_now("sb_empty");
          end else begin
            e = sb.pop_front();
            chk("y8", u8_y, e.y);
            chk("y1", u1_y, e.y[0]);
            chk("sel8", {u8_s2, u8_s1, u8_s0}, e.s);
            chk("sel1", {u1_s2, u1_s1, u1_s0}, e.s);
            chk("fs", {u8_fs, u1_fs}, {2{e.fs}});
            chk("valid", {u8_yv, u1_yv, u8_busy, u1_busy}, 4'hf);
            chk("demux", dmx, 8'(e.y[0]) << e.s);
          end
        end else begin
          chk("idle_y", {u8_y, u1_y}, 9'h0);
          chk("idle_sel", {u8_s2, u8_s1, u8_s0, u1_s2, u1_s1, u1_s0}, 6'h0);
          chk("idle_flags", {u8_yv, u8_fs, u8_busy, u1_yv, u1_fs, u1_busy}, 6'h0);
          chk("idle_demux", dmx, 8'h0);
        end
      end
    end
  end

  task automatic send(input logic [7:0] f[8]);
    int  n0;
    bit  ok;
    din = f;
    load_valid = 1'b1;
    n0 = acc_cnt;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_cnt != n0) begin
        ok = 1'b1;
        break;
      end
    end
    load_valid = 1'b0;
    if (!ok) fail_now("load_timeout");
  endtask

  initial begin
    vec_t       tbl[10];
    logic       p[8];
    logic [7:0] fa[8];
    logic [7:0] fb[8];
    logic [7:0] fg[8];
    for (int k = 0; k < 8; k++) din[k] = 8'hff;

    // Reset held with a load offered: nothing may start.
    load_valid = 1'b1;
    #2;
    chk("rst_outs", {u8_y, u8_yv, u8_fs, u8_busy}, 11'h0);
    chk("rst_ready", u8_rdy, 1'b1);
    repeat (3) tick();
    load_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();

    // Single frame as a cycle table.
    p = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) din[k] = {7'h0, p[k]};
    tbl[0] = '{lv: 1'b1, ab: 1'b0, v: 1'b0, y: 8'h0, s: 3'd0, fs: 1'b0, rdy: 1'b1};
    for (int k = 0; k < 8; k++)
      tbl[k+1] = '{lv: 1'b0, ab: 1'b0, v: 1'b1, y: {7'h0, p[k]},
                   s: 3'(k), fs: (k == 0), rdy: (k == 7)};
    tbl[9] = '{lv: 1'b0, ab: 1'b0, v: 1'b0, y: 8'h0, s: 3'd0, fs: 1'b0, rdy: 1'b1};
    for (int i = 0; i < 10; i++) begin
      load_valid = tbl[i].lv;
      abort = tbl[i].ab;
      #2;
      chk($sformatf("tbl%0d_v", i), u1_yv, tbl[i].v);
      chk($sformatf("tbl%0d_y", i), u1_y, tbl[i].y[0]);
      chk($sformatf("tbl%0d_s", i), {u1_s2, u1_s1, u1_s0}, tbl[i].s);
      chk($sformatf("tbl%0d_fs", i), u1_fs, tbl[i].fs);
      chk($sformatf("tbl%0d_rdy", i), u1_rdy, tbl[i].rdy);
      tick();
    end

    // Back-to-back frames.
    for (int k = 0; k < 8; k++) begin
      fa[k] = 8'h10 + 8'(k);
      fb[k] = 8'h20 + 8'(k);
      fg[k] = 8'h40 + 8'(k);
    end
    fs_t.delete();
    send(fa);
    send(fb);
    repeat (9) tick();
    chk("fs_count", fs_t.size(), 2);
    if (fs_t.size() >= 2) chk("fs_gap", fs_t[1] - fs_t[0], 80);

    // Isolation of the frame in flight and stalled load.
    send(fa);
    tick();
    tick();
    for (int k = 0; k < 8; k++) din[k] = 8'hee;
    tick();
    tick();
    din = fg;
    load_valid = 1'b1;
    #1;
    chk("stall_ready", u8_rdy, 1'b0);
    tick();
    tick();
    tick();
    chk("slot7_ready", u8_rdy, 1'b1);
    tick();
    load_valid = 1'b0;
    #1;
    chk("pend_fs", u8_fs, 1'b1);
    chk("pend_y", u8_y, 8'h40);
    repeat (9) tick();

    // Abort in slot 3 with a competing load.
    send(fb);
    repeat (3) tick();
    abort = 1'b1;
    load_valid = 1'b1;
    din = fg;
    #1;
    chk("abort_ready", u8_rdy, 1'b0);
    tick();
    abort = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("abort_clr", {u8_yv, u8_busy, u8_y}, 10'h0);
    tick();
    send(fa);
    #1;
    chk("restart_sel", {u8_s2, u8_s1, u8_s0}, 3'd0);
    repeat (9) tick();

    // Asynchronous reset in the middle of slot 5.
    send(fb);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flags", {u8_yv, u8_busy, u8_fs}, 3'h0);
    chk("arst_data", {u8_y, u8_s2, u8_s1, u8_s0}, 11'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Loopback with random single-bit frames.
    for (int n = 0; n < 256; n++) begin
      for (int k = 0; k < 8; k++) fa[k] = 8'($urandom_range(0, 1));
      send(fa);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 10)) tick();
    end
    repeat (10) tick();
    chk("sb_drained", sb.size(), 0);
    mon_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
